// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback stage and the ALU it feeds:
// widths, opcodes, instruction field layout and FSM states.
package alu_pkg;

  localparam int ALU_N   = 32;
  localparam int ALU_AW  = 3;
  localparam int OP_W    = 3;
  localparam int INSTR_W = 12;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;

  // Every opcode at or above this value has no ALU function.
  localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = 3'b101;

  localparam int OP_LSB  = 9;
  localparam int RD_LSB  = 6;
  localparam int RS1_LSB = 3;
  localparam int RS2_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
    return (op >= OP_ILLEGAL_MIN);
  endfunction

endpackage

// File: rtl/Optimized_ALU.sv
// Combinational N-bit ALU: add/sub with signed overflow, and/or/xor.
// Opcodes without a function produce zero.
module Optimized_ALU
  import alu_pkg::*;
#(
  parameter int N = ALU_N
) (
  input  logic [N-1:0]    A,
  input  logic [N-1:0]    B,
  input  logic [OP_W-1:0] OP,
  output logic [N-1:0]    C,
  output logic            OV
);

  // Overflow is the two's-complement rule: operand signs vs. result sign.
  always_comb begin
    C  = '0;
    OV = 1'b0;
    case (OP)
      OP_ADD: begin
        C  = A + B;
        OV = (A[N-1] == B[N-1]) && (C[N-1] != A[N-1]);
      end
      OP_SUB: begin
        C  = A - B;
        OV = (A[N-1] != B[N-1]) && (C[N-1] != A[N-1]);
      end
      OP_AND:  C = A & B;
      OP_OR:   C = A | B;
      OP_XOR:  C = A ^ B;
      default: C = '0;
    endcase
  end

endmodule

// File: rtl/alu_reg_file.sv
// Register file with two combinational read ports, a host load port and an
// ALU writeback port; R0 always reads zero and ignores writes.
module alu_reg_file
  import alu_pkg::*;
#(
  parameter int N  = ALU_N,
  parameter int AW = ALU_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [N-1:0]  rd_data_a,
  output logic [N-1:0]  rd_data_b,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [N-1:0]  ld_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [N-1:0]  wb_data
);

  localparam int DEPTH = 2 ** AW;

  logic [N-1:0] regs [DEPTH];

  // Writeback is applied after the host load so it wins on an address clash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (ld_en && (ld_addr != '0)) begin
        regs[ld_addr] <= ld_data;
      end
      if (wb_en && (wb_addr != '0)) begin
        regs[wb_addr] <= wb_data;
      end
    end
  end

  assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/alu_issue_unit.sv
// Operand-fetch / writeback stage in front of Optimized_ALU: accepts an
// instruction, drives registered operands, writes back C and reports it.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int N  = ALU_N,
  parameter int AW = ALU_AW
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [INSTR_W-1:0] INSTR,
  output logic [N-1:0]       A,
  output logic [N-1:0]       B,
  output logic [OP_W-1:0]    OP,
  input  logic [N-1:0]       C,
  input  logic               OV,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [N-1:0]       RESULT,
  output logic               RESULT_OV,
  output logic [AW-1:0]      RESULT_RD,
  output logic               ILLEGAL,
  output logic               OV_STICKY,
  input  logic               CLR_OV,
  input  logic               LD_EN,
  input  logic [AW-1:0]      LD_ADDR,
  input  logic [N-1:0]       LD_DATA
);

  state_t state, state_next;

  logic            accept;
  logic            exec_done;
  logic            wb_en;
  logic [AW-1:0]   rd_q;
  logic            illegal_q;
  logic [N-1:0]    rf_a;
  logic [N-1:0]    rf_b;
  logic [OP_W-1:0] instr_op;
  logic [AW-1:0]   instr_rd;
  logic [AW-1:0]   instr_rs1;
  logic [AW-1:0]   instr_rs2;

  assign instr_op  = INSTR[OP_LSB  +: OP_W];
  assign instr_rd  = INSTR[RD_LSB  +: AW];
  assign instr_rs1 = INSTR[RS1_LSB +: AW];
  assign instr_rs2 = INSTR[RS2_LSB +: AW];

  alu_reg_file #(
    .N  (N),
    .AW (AW)
  ) u_reg_file (
    .clk       (CLK),
    .rst       (RST),
    .rd_addr_a (instr_rs1),
    .rd_addr_b (instr_rs2),
    .rd_data_a (rf_a),
    .rd_data_b (rf_b),
    .ld_en     (LD_EN),
    .ld_addr   (LD_ADDR),
    .ld_data   (LD_DATA),
    .wb_en     (wb_en),
    .wb_addr   (rd_q),
    .wb_data   (C)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    exec_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (IN_VALID) begin
          accept     = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        exec_done  = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        if (OUT_READY) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign IN_READY  = (state == ST_IDLE);
  assign OUT_VALID = (state == ST_DONE);
  assign wb_en     = exec_done && !illegal_q;

  // Operands are sampled from the old register contents on the accept edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      A         <= '0;
      B         <= '0;
      OP        <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      A         <= rf_a;
      B         <= rf_b;
      OP        <= instr_op;
      rd_q      <= instr_rd;
      illegal_q <= is_illegal_op(instr_op);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RESULT    <= '0;
      RESULT_OV <= 1'b0;
      RESULT_RD <= '0;
      ILLEGAL   <= 1'b0;
    end else if (exec_done) begin
      RESULT    <= illegal_q ? '0 : C;
      RESULT_OV <= !illegal_q && OV;
      RESULT_RD <= rd_q;
      ILLEGAL   <= illegal_q;
    end
  end

  // A new overflow takes precedence over a coincident clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OV_STICKY <= 1'b0;
    end else if (wb_en && OV) begin
      OV_STICKY <= 1'b1;
    end else if (CLR_OV) begin
      OV_STICKY <= 1'b0;
    end
  end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Operand-fetch and writeback stage that sits directly upstream of the Optimized_ALU (N=32, 3-bit OP, result C, overflow OV) and consumes its result. Accepts 12-bit register-register instructions over a valid/ready handshake, reads two operands from an internal 8×N register file, and drives registered A/B/OP to the ALU. It then writes C back to the destination register and presents the result on an output valid/ready handshake. Also owns a sticky overflow flag and a host load port for initialising registers.

## Interface
- N, 32, datapath width (must match the ALU's N)
- AW, 3, register address width; register count = 2**AW
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- IN_VALID  in  1  instruction valid
- IN_READY  out  1  instruction accepted when IN_VALID && IN_READY at a rising edge
- INSTR  in  12  [11:9]=OP, [8:6]=RD, [5:3]=RS1, [2:0]=RS2
- A, B  out  N  ALU operands, registered
- OP  out  3  ALU opcode, registered
- C  in  N  ALU result, combinational from A/B/OP
- OV  in  1  ALU overflow
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  result consumed when OUT_VALID && OUT_READY at a rising edge
- RESULT  out  N  captured C (0 for illegal op)
- RESULT_OV  out  1  captured OV (0 for illegal op)
- RESULT_RD  out  AW  destination of the result
- ILLEGAL  out  1  the result belongs to an illegal opcode
- OV_STICKY  out  1  set by any legal op with OV=1; cleared by CLR_OV
- CLR_OV  in  1  synchronous clear of OV_STICKY
- LD_EN  in  1  host register write
- LD_ADDR  in  AW  host write address
- LD_DATA  in  N  host write data

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: IN_READY=1. On handshake:
  - capture A=RF[RS1], B=RF[RS2], OP, RD, and illegal = (OP ≥ 3'b101).
  - go to EXEC.
- EXEC: ALU evaluates C/OV combinationally. At the edge leaving EXEC:
  - legal op: RF[RD]←C (ignored if RD=0), RESULT←C, RESULT_OV←OV, OV_STICKY←1 if OV.
  - illegal op: no RF write; RESULT=0, RESULT_OV=0, ILLEGAL=1.
  - go to DONE.
- DONE: OUT_VALID=1, with outputs held stable until OUT_READY; then go to IDLE.
- Opcodes: 000 add, 001 sub, 010 and, 011 or, 100 xor; 101–111 are illegal.
- R0 reads as 0 always; writes to R0 (writeback or host load) are dropped.
- Host load: RF[LD_ADDR]←LD_DATA in any state.
  - Same address as an EXEC writeback in the same cycle: writeback wins.
  - A load to RS1/RS2 in the IDLE accept cycle is not seen by that instruction (reads sample the old value).
- CLR_OV and a new overflow set in the same cycle: set wins.

## Timing
- Reset values: all RF entries 0, state IDLE, A=B=0, OP=0, IN_READY=1, OUT_VALID=0, RESULT=0, RESULT_OV=0, RESULT_RD=0, ILLEGAL=0, OV_STICKY=0.
- Accept at edge t → A/B/OP valid after t (EXEC) → RF write and RESULT capture at t+1 → OUT_VALID high after t+1.
- Minimum issue interval is 3 cycles; there are no hazards, because writeback completes before IN_READY reasserts.
- OUT_READY held low: stay in DONE indefinitely with IN_READY=0.
- RST mid-operation: immediate return to reset values; the in-flight instruction is discarded and its writeback is not performed.
- IN_VALID outside IDLE is ignored, and INSTR is not sampled.

## Structure
- Shared package alu_pkg: N default, opcode localparams (OP_ADD…OP_XOR), the illegal-opcode threshold, INSTR field offsets, and state encodings.
- One sub-module: alu_reg_file (2 async read ports, 2 write ports with writeback priority, R0 hardwired to 0).
- FSM and capture registers live in alu_issue_unit.
- The bench instantiates alu_issue_unit connected to Optimized_ALU.

## Test plan
- Load R1=345, R2=234; issue OP=000 RD=3 RS1=1 RS2=2 → A=345, B=234 in EXEC; RESULT=579, RESULT_RD=3, OUT_VALID; a subsequent read of R3 gives 579.
- Load R1=32'h7FFFFFFF, R2=1; issue add RD=4 → RESULT_OV=1 and OV_STICKY=1; pulse CLR_OV → OV_STICKY=0; CLR_OV coincident with a second overflow → OV_STICKY stays 1.
- Issue OP=110 RD=5 with R5 preloaded to 77 → ILLEGAL=1, RESULT=0, R5 still 77, OV_STICKY unchanged.
- Issue add with RD=0 → RESULT=579 is reported, R0 still reads 0; hold OUT_READY=0 for 5 cycles → OUT_VALID held, IN_READY=0, and an IN_VALID pulse is ignored.
- LD_EN to R3 with value 9 in the same cycle as the EXEC writeback of 579 to R3 → R3=579.
- Assert RST during EXEC → all outputs return to reset values next cycle, no RF write occurs, and IN_READY=1.
